// File: rtl/mem_arbiter.sv
// Single-port memory arbiter for the 5-stage pipeline: fetch (P1) and load/store (P4) share one
// synchronous memory; read tags route returning m_q data and drive the pipeline stall.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        if_req,
    input  logic [11:0] if_addr,
    output logic        if_gnt,
    output logic        if_valid,
    output logic [15:0] if_rdata,

    input  logic        d_req,
    input  logic        d_we,
    input  logic [11:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_gnt,
    output logic        d_valid,
    output logic [15:0] d_rdata,

    output logic        stall,

    output logic [11:0] m_addr,
    output logic [15:0] m_data,
    output logic        m_rw,
    input  logic [15:0] m_q
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

    typedef struct packed {
        logic   valid;
        owner_e owner;
    } tag_t;

    logic [3:0]  r_starve_cnt;
    logic [11:0] r_m_addr;
    logic [15:0] r_m_data;
    logic        r_m_rw;
    tag_t        r_tag1;
    tag_t        r_tag2;

    logic        w_d_gnt;
    logic        w_if_gnt;
    logic        w_if_denied;
    logic        w_load_pending;
    tag_t        w_tag_in;

    // Data wins unless fetch has been denied STARVE_LIMIT cycles in a row.
    assign w_d_gnt     = d_req & ((r_starve_cnt < LIMIT) | ~if_req);
    assign w_if_gnt    = if_req & ~w_d_gnt;
    assign w_if_denied = if_req & ~w_if_gnt;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_tag_in = '{valid: 1'b0, owner: OWN_IF};
        if (w_d_gnt) begin
            w_tag_in = '{valid: ~d_we, owner: OWN_D};
        end else if (w_if_gnt) begin
            w_tag_in = '{valid: 1'b1, owner: OWN_IF};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_m_addr <= '0;
            r_m_data <= '0;
            r_m_rw   <= 1'b0;
        end else if (w_d_gnt) begin
            r_m_addr <= d_addr;
            r_m_rw   <= d_we;
            if (d_we) begin
                r_m_data <= d_wdata;
            end
        end else if (w_if_gnt) begin
            r_m_addr <= if_addr;
            r_m_rw   <= 1'b0;
        end else begin
            r_m_rw   <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_starve_cnt <= '0;
        end else if (!w_if_denied) begin
            r_starve_cnt <= '0;
        end else if (r_starve_cnt < LIMIT) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
        end
    end

    // Clearing both stages on reset drops any read already in flight.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_tag1 <= '{valid: 1'b0, owner: OWN_IF};
            r_tag2 <= '{valid: 1'b0, owner: OWN_IF};
        end else begin
            r_tag1 <= w_tag_in;
            r_tag2 <= r_tag1;
        end
    end

    assign w_load_pending = (r_tag1.valid & (r_tag1.owner == OWN_D)) |
                            (r_tag2.valid & (r_tag2.owner == OWN_D));

    assign if_gnt   = w_if_gnt;
    assign d_gnt    = w_d_gnt;
    assign if_valid = r_tag2.valid & (r_tag2.owner == OWN_IF);
    assign d_valid  = r_tag2.valid & (r_tag2.owner == OWN_D);
    assign if_rdata = m_q;
    assign d_rdata  = m_q;
    assign stall    = w_if_denied | (d_req & ~w_d_gnt) | w_load_pending;
    assign m_addr   = r_m_addr;
    assign m_data   = r_m_data;
    assign m_rw     = r_m_rw;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a synchronous memory model plus per-scenario tasks with
// hand-computed expectations.
module tb_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        if_req, d_req, d_we;
    logic [11:0] if_addr, d_addr;
    logic [15:0] d_wdata;
    logic        if_gnt, if_valid, d_gnt, d_valid, stall, m_rw;
    logic [15:0] if_rdata, d_rdata, m_data, m_q;
    logic [11:0] m_addr;

    logic [15:0] mem [0:4095];
    int n_compared   = 0;
    int n_mismatched = 0;

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
        .stall(stall), .m_addr(m_addr), .m_data(m_data), .m_rw(m_rw), .m_q(m_q)
    );

    always #5 clock = ~clock;

    // Memory: samples m_addr on the rising edge, read data valid the following cycle.
    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 16'h5000 + 16'(i);
        for (int i = 0; i < 4; i++) mem[i] = 16'h1000 + 16'(i);
        mem[12'h020] = 16'hBEEF;
        forever begin
            @(posedge clock);
            if (m_rw) mem[m_addr] = m_data;
            m_q <= mem[m_addr];
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; if_req = 1'b1; if_addr = 12'h010;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        for (int c = 0; c < 2; c++) begin
            tick();
            @(negedge clock);
            n_compared++; if (m_rw !== 1'b0) begin n_mismatched++; $display("FAIL rst_m_rw: got %b want 0", m_rw); end
            n_compared++; if (m_addr !== 12'h000) begin n_mismatched++; $display("FAIL rst_m_addr: got %h want 000", m_addr); end
            n_compared++; if (m_data !== 16'h0000) begin n_mismatched++; $display("FAIL rst_m_data: got %h want 0000", m_data); end
            n_compared++; if ({if_valid, d_valid} !== 2'b00) begin n_mismatched++; $display("FAIL rst_valid: got %b want 00", {if_valid, d_valid}); end
        end
        tick();
        reset = 1'b1;
        @(negedge clock);
        n_compared++; if ({if_gnt, d_gnt} !== 2'b10) begin n_mismatched++; $display("FAIL rel_gnt: got %b want 10", {if_gnt, d_gnt}); end
        n_compared++; if (stall !== 1'b0) begin n_mismatched++; $display("FAIL rel_stall: got %b want 0", stall); end
        tick();
        if_req = 1'b0;
        @(negedge clock);
        n_compared++; if (m_addr !== 12'h010) begin n_mismatched++; $display("FAIL rel_m_addr: got %h want 010", m_addr); end
        n_compared++; if (if_valid !== 1'b0) begin n_mismatched++; $display("FAIL rel_early_valid: got %b want 0", if_valid); end
        tick();
        @(negedge clock);
        n_compared++; if (if_valid !== 1'b1) begin n_mismatched++; $display("FAIL rel_if_valid: got %b want 1", if_valid); end
        n_compared++; if (if_rdata !== 16'h5010) begin n_mismatched++; $display("FAIL rel_if_rdata: got %h want 5010", if_rdata); end
        n_compared++; if (d_valid !== 1'b0) begin n_mismatched++; $display("FAIL rel_d_valid: got %b want 0", d_valid); end
    endtask

    task automatic test_fetch_stream();
        for (int c = 0; c < 6; c++) begin
            tick();
            if_req  = (c < 4);
            if_addr = 12'(c);
            @(negedge clock);
            n_compared++; if (stall !== 1'b0) begin n_mismatched++; $display("FAIL fs_stall[%0d]: got %b want 0", c, stall); end
            n_compared++; if (if_valid !== (c >= 2)) begin n_mismatched++; $display("FAIL fs_valid[%0d]: got %b want %b", c, if_valid, (c >= 2)); end
            if (c < 4) begin
                n_compared++; if (if_gnt !== 1'b1) begin n_mismatched++; $display("FAIL fs_gnt[%0d]: got %b want 1", c, if_gnt); end
            end
            if (c >= 2) begin
                n_compared++; if (if_rdata !== 16'h1000 + 16'(c - 2)) begin n_mismatched++; $display("FAIL fs_data[%0d]: got %h want %h", c, if_rdata, 16'h1000 + 16'(c - 2)); end
            end
        end
        if_req = 1'b0;
    endtask

    task automatic test_load_collision();
        tick();
        if_req = 1'b1; if_addr = 12'h005;
        d_req = 1'b1; d_we = 1'b0; d_addr = 12'h020;
        @(negedge clock);
        n_compared++; if ({if_gnt, d_gnt} !== 2'b01) begin n_mismatched++; $display("FAIL lc_gnt_n: got %b want 01", {if_gnt, d_gnt}); end
        n_compared++; if (stall !== 1'b1) begin n_mismatched++; $display("FAIL lc_stall_n: got %b want 1", stall); end
        tick();
        d_req = 1'b0;
        @(negedge clock);
        n_compared++; if ({if_gnt, d_gnt} !== 2'b10) begin n_mismatched++; $display("FAIL lc_gnt_n1: got %b want 10", {if_gnt, d_gnt}); end
        n_compared++; if (stall !== 1'b1) begin n_mismatched++; $display("FAIL lc_stall_n1: got %b want 1", stall); end
        tick();
        if_req = 1'b0;
        @(negedge clock);
        n_compared++; if (d_valid !== 1'b1) begin n_mismatched++; $display("FAIL lc_d_valid: got %b want 1", d_valid); end
        n_compared++; if (d_rdata !== 16'hBEEF) begin n_mismatched++; $display("FAIL lc_d_rdata: got %h want beef", d_rdata); end
        n_compared++; if (stall !== 1'b1) begin n_mismatched++; $display("FAIL lc_stall_n2: got %b want 1", stall); end
        n_compared++; if (if_valid !== 1'b0) begin n_mismatched++; $display("FAIL lc_if_valid_n2: got %b want 0", if_valid); end
        tick();
        @(negedge clock);
        n_compared++; if (stall !== 1'b0) begin n_mismatched++; $display("FAIL lc_stall_n3: got %b want 0", stall); end
        n_compared++; if ({if_valid, d_valid} !== 2'b10) begin n_mismatched++; $display("FAIL lc_valid_n3: got %b want 10", {if_valid, d_valid}); end
        n_compared++; if (if_rdata !== 16'h5005) begin n_mismatched++; $display("FAIL lc_if_rdata: got %h want 5005", if_rdata); end
    endtask

    task automatic test_store_then_load();
        tick();
        d_req = 1'b1; d_we = 1'b1; d_addr = 12'h040; d_wdata = 16'h1234;
        @(negedge clock);
        n_compared++; if (d_gnt !== 1'b1) begin n_mismatched++; $display("FAIL sl_st_gnt: got %b want 1", d_gnt); end
        n_compared++; if (stall !== 1'b0) begin n_mismatched++; $display("FAIL sl_stall_s: got %b want 0", stall); end
        tick();
        d_we = 1'b0; d_wdata = 16'h0000;
        @(negedge clock);
        n_compared++; if (d_gnt !== 1'b1) begin n_mismatched++; $display("FAIL sl_ld_gnt: got %b want 1", d_gnt); end
        n_compared++; if ({m_rw, m_addr, m_data} !== {1'b1, 12'h040, 16'h1234}) begin n_mismatched++; $display("FAIL sl_mem_port: got %b/%h/%h want 1/040/1234", m_rw, m_addr, m_data); end
        tick();
        d_req = 1'b0;
        @(negedge clock);
        n_compared++; if (d_valid !== 1'b0) begin n_mismatched++; $display("FAIL sl_store_pulse: got %b want 0", d_valid); end
        n_compared++; if (m_rw !== 1'b0) begin n_mismatched++; $display("FAIL sl_m_rw_ld: got %b want 0", m_rw); end
        n_compared++; if (stall !== 1'b1) begin n_mismatched++; $display("FAIL sl_stall_pend: got %b want 1", stall); end
        tick();
        @(negedge clock);
        n_compared++; if (d_valid !== 1'b1) begin n_mismatched++; $display("FAIL sl_ld_valid: got %b want 1", d_valid); end
        n_compared++; if (d_rdata !== 16'h1234) begin n_mismatched++; $display("FAIL sl_ld_data: got %h want 1234", d_rdata); end
        tick();
        @(negedge clock);
        n_compared++; if ({d_valid, stall} !== 2'b00) begin n_mismatched++; $display("FAIL sl_idle: got %b want 00", {d_valid, stall}); end
    endtask

    task automatic test_starvation();
        logic [11:0] exp_if_pat;
        exp_if_pat = 12'b0010_0001_0000;
        for (int c = 0; c < 12; c++) begin
            tick();
            if_req = 1'b1; if_addr = 12'h008;
            d_req = 1'b1; d_we = 1'b0; d_addr = 12'h030;
            @(negedge clock);
            n_compared++; if ({if_gnt, d_gnt} !== {exp_if_pat[c], ~exp_if_pat[c]}) begin n_mismatched++; $display("FAIL sv_gnt[%0d]: got %b want %b", c, {if_gnt, d_gnt}, {exp_if_pat[c], ~exp_if_pat[c]}); end
            n_compared++; if (stall !== 1'b1) begin n_mismatched++; $display("FAIL sv_stall[%0d]: got %b want 1", c, stall); end
            if (c >= 2) begin
                n_compared++; if ({if_valid, d_valid} !== {exp_if_pat[c - 2], ~exp_if_pat[c - 2]}) begin n_mismatched++; $display("FAIL sv_valid[%0d]: got %b want %b", c, {if_valid, d_valid}, {exp_if_pat[c - 2], ~exp_if_pat[c - 2]}); end
            end
        end
        tick();
        if_req = 1'b0; d_req = 1'b0;
        tick();
        tick();
        @(negedge clock);
        n_compared++; if ({stall, m_rw, if_valid, d_valid} !== 4'b0000) begin n_mismatched++; $display("FAIL sv_drain: got %b want 0000", {stall, m_rw, if_valid, d_valid}); end
    endtask

    task automatic test_reset_mid_read();
        tick();
        d_req = 1'b1; d_we = 1'b0; d_addr = 12'h020;
        @(negedge clock);
        n_compared++; if (d_gnt !== 1'b1) begin n_mismatched++; $display("FAIL rm_gnt: got %b want 1", d_gnt); end
        tick();
        d_req = 1'b0; reset = 1'b0;
        @(negedge clock);
        n_compared++; if (d_valid !== 1'b0) begin n_mismatched++; $display("FAIL rm_valid_m1: got %b want 0", d_valid); end
        tick();
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            n_compared++; if ({d_valid, if_valid} !== 2'b00) begin n_mismatched++; $display("FAIL rm_valid[%0d]: got %b want 00", c, {d_valid, if_valid}); end
            n_compared++; if (stall !== 1'b0) begin n_mismatched++; $display("FAIL rm_stall[%0d]: got %b want 0", c, stall); end
            n_compared++; if ({m_rw, m_addr} !== {1'b0, 12'h000}) begin n_mismatched++; $display("FAIL rm_mem[%0d]: got %b/%h want 0/000", c, m_rw, m_addr); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_fetch_stream();
        test_load_collision();
        test_store_then_load();
        test_starvation();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
